// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Also holds the Tnew/Tuse RAW compare used for every operand/stage pair.
package pipe_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam int         MULT_CYC_DEF    = 5;
  localparam int         DIV_CYC_DEF     = 10;
  localparam int         MEM_TIMEOUT_DEF = 255;

  // A producer blocks the reader only if its value is not ready by the time ID needs it.
  function automatic logic raw_hit(
    input logic [4:0] a_id,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic       reg_write,
    input logic [1:0] tnew
  );
    return (a_id != 5'd0) && (a_id == a3) && reg_write &&
           (tuse != TUSE_NONE) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Mult/div busy timer: starts when a mult/div leaves EX, counts down the
// unit latency, and pulses done the cycle busy drops.
module md_timer
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  input  logic freeze,
  output logic busy,
  output logic done
);

  md_state_t   state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        done_q, next_done;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MD_IDLE;
      cnt    <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      done_q <= next_done;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = 1'b0;
    case (state)
      MD_IDLE: begin
        // A start held in EX by a memory freeze has not left EX yet.
        if (start && !freeze) begin
          next_state = MD_BUSY;
          next_cnt   = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end
      end
      MD_BUSY: begin
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = MD_IDLE;
          next_done  = 1'b1;
        end
      end
      default: next_state = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
    done = done_q;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: RAW hazards, mult/div
// interlock, data-memory freeze, memory timeout flag and stall statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC    = MULT_CYC_DEF,
  parameter int DIV_CYC     = DIV_CYC_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1_ID,
  input  logic [4:0]  A2_ID,
  input  logic [1:0]  Tuse_rs_ID,
  input  logic [1:0]  Tuse_rt_ID,
  input  logic [4:0]  A3_EX,
  input  logic        RegWrite_EX,
  input  logic [1:0]  Tnew_EX,
  input  logic [4:0]  A3_MEM,
  input  logic        RegWrite_MEM,
  input  logic [1:0]  Tnew_MEM,
  input  logic        md_use_ID,
  input  logic        md_start_EX,
  input  logic        md_div_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ready,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        stall_WB,
  output logic        flush_EX,
  output logic        md_busy,
  output logic        md_done,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  logic       rs_haz, rt_haz, md_haz;
  logic       freeze, hstall;
  logic [8:0] wait_cnt;

  always_comb begin
    rs_haz = raw_hit(A1_ID, Tuse_rs_ID, A3_EX,  RegWrite_EX,  Tnew_EX) |
             raw_hit(A1_ID, Tuse_rs_ID, A3_MEM, RegWrite_MEM, Tnew_MEM);
    rt_haz = raw_hit(A2_ID, Tuse_rt_ID, A3_EX,  RegWrite_EX,  Tnew_EX) |
             raw_hit(A2_ID, Tuse_rt_ID, A3_MEM, RegWrite_MEM, Tnew_MEM);
    md_haz = md_use_ID & (md_busy | md_start_EX);
    freeze = dmem_req_MEM & ~dmem_ready;
    // Freeze outranks a hazard: no bubble may enter while EX is held.
    hstall = (rs_haz | rt_haz | md_haz) & ~freeze;
  end

  always_comb begin
    stall_IF  = hstall | freeze;
    stall_ID  = hstall | freeze;
    flush_EX  = hstall;
    stall_EX  = freeze;
    stall_MEM = freeze;
    stall_WB  = freeze;
  end

  md_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_EX),
    .is_div (md_div_EX),
    .freeze (freeze),
    .busy   (md_busy),
    .done   (md_done)
  );

  // NOTE: only control/status flops live here, so all of them are reset;
  // there is no storage array that could be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= 9'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= 16'd0;
    end else begin
      if (!freeze)
        wait_cnt <= 9'd0;
      else if (wait_cnt != 9'h1FF)
        wait_cnt <= wait_cnt + 9'd1;

      if (wait_cnt == 9'(MEM_TIMEOUT))
        mem_timeout <= 1'b1;

      if (hstall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stimulus pushes hand-derived expectations
// into a queue, a negedge monitor pops and compares them against the outputs.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1_ID, A2_ID, A3_EX, A3_MEM;
  logic [1:0]  Tuse_rs_ID, Tuse_rt_ID, Tnew_EX, Tnew_MEM;
  logic        RegWrite_EX, RegWrite_MEM;
  logic        md_use_ID, md_start_EX, md_div_EX, dmem_req_MEM, dmem_ready;
  logic        stall_IF, stall_ID, stall_EX, stall_MEM, stall_WB, flush_EX;
  logic        md_busy, md_done, mem_timeout;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .A1_ID        (A1_ID),
    .A2_ID        (A2_ID),
    .Tuse_rs_ID   (Tuse_rs_ID),
    .Tuse_rt_ID   (Tuse_rt_ID),
    .A3_EX        (A3_EX),
    .RegWrite_EX  (RegWrite_EX),
    .Tnew_EX      (Tnew_EX),
    .A3_MEM       (A3_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .Tnew_MEM     (Tnew_MEM),
    .md_use_ID    (md_use_ID),
    .md_start_EX  (md_start_EX),
    .md_div_EX    (md_div_EX),
    .dmem_req_MEM (dmem_req_MEM),
    .dmem_ready   (dmem_ready),
    .stall_IF     (stall_IF),
    .stall_ID     (stall_ID),
    .stall_EX     (stall_EX),
    .stall_MEM    (stall_MEM),
    .stall_WB     (stall_WB),
    .flush_EX     (flush_EX),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    string       nm;
    logic [4:0]  stalls;   // {IF, ID, EX, MEM, WB}
    logic        flush;
    logic        busy;
    logic        done;
    logic        tout;
    logic        chk_tout;
    logic [15:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_scnt = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Monitor: outputs are settled mid-cycle, half a period after inputs change.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.nm, "/stalls"}, 16'({stall_IF, stall_ID, stall_EX, stall_MEM, stall_WB}), 16'(e.stalls));
      check({e.nm, "/flush"},  16'(flush_EX), 16'(e.flush));
      check({e.nm, "/busy"},   16'(md_busy),  16'(e.busy));
      check({e.nm, "/done"},   16'(md_done),  16'(e.done));
      if (e.chk_tout)
        check({e.nm, "/timeout"}, 16'(mem_timeout), 16'(e.tout));
      check({e.nm, "/stall_cnt"}, stall_cnt, e.scnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    A1_ID = 5'd0; A2_ID = 5'd0; Tuse_rs_ID = TUSE_NONE; Tuse_rt_ID = TUSE_NONE;
    A3_EX = 5'd0; RegWrite_EX = 1'b0; Tnew_EX = 2'd0;
    A3_MEM = 5'd0; RegWrite_MEM = 1'b0; Tnew_MEM = 2'd0;
    md_use_ID = 1'b0; md_start_EX = 1'b0; md_div_EX = 1'b0;
    dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
  endtask

  // hs: expected hazard stall (bubble), fr: expected memory freeze.
  task automatic expect_out(input string nm, input bit hs, input bit fr, input bit busy,
                            input bit done, input bit tout, input bit chk_tout = 1'b1);
    exp_t e;
    e.nm       = nm;
    e.stalls   = {hs | fr, hs | fr, fr, fr, fr};
    e.flush    = hs;
    e.busy     = busy;
    e.done     = done;
    e.tout     = tout;
    e.chk_tout = chk_tout;
    e.scnt     = 16'(exp_scnt);
    exp_q.push_back(e);
    if (hs) exp_scnt++;
  endtask

  task automatic md_seq(input bit dv, input int n);
    tick(); clear_in(); md_use_ID = 1'b1; md_start_EX = 1'b1; md_div_EX = dv;
    expect_out(dv ? "div_start" : "mult_start", 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      tick(); md_start_EX = 1'b0; md_div_EX = 1'b0;
      expect_out(dv ? "div_busy" : "mult_busy", 1, 0, 1, 0, 0);
    end
    tick(); expect_out(dv ? "div_done" : "mult_done", 0, 0, 0, 1, 0);
    tick(); clear_in(); expect_out(dv ? "div_after" : "mult_after", 0, 0, 0, 0, 0);
  endtask

  initial begin
    int w;
    rst = 1'b0;
    clear_in();
    tick(); expect_out("reset", 0, 0, 0, 0, 0);
    tick(); rst = 1'b1; expect_out("idle", 0, 0, 0, 0, 0);

    // RAW on rs: producer in EX, then the same producer one stage later in MEM.
    tick(); A1_ID = 5'd5; Tuse_rs_ID = 2'd0; A3_EX = 5'd5; RegWrite_EX = 1'b1; Tnew_EX = 2'd2;
    expect_out("raw_ex", 1, 0, 0, 0, 0);
    tick(); A3_EX = 5'd0; RegWrite_EX = 1'b0; Tnew_EX = 2'd0;
    A3_MEM = 5'd5; RegWrite_MEM = 1'b1; Tnew_MEM = 2'd1;
    expect_out("raw_mem", 1, 0, 0, 0, 0);
    tick(); clear_in(); expect_out("raw_release", 0, 0, 0, 0, 0);

    tick(); Tuse_rs_ID = 2'd0; RegWrite_EX = 1'b1; Tnew_EX = 2'd2;
    expect_out("r0_no_haz", 0, 0, 0, 0, 0);
    tick(); clear_in(); A1_ID = 5'd5; Tuse_rs_ID = 2'd1; A3_EX = 5'd5; RegWrite_EX = 1'b1; Tnew_EX = 2'd1;
    expect_out("tnew_eq_tuse", 0, 0, 0, 0, 0);
    tick(); clear_in(); A2_ID = 5'd7; Tuse_rt_ID = 2'd0; A3_MEM = 5'd7; RegWrite_MEM = 1'b1; Tnew_MEM = 2'd1;
    expect_out("raw_rt_mem", 1, 0, 0, 0, 0);
    tick(); clear_in(); A2_ID = 5'd7; Tuse_rt_ID = 2'd0; A3_EX = 5'd7; RegWrite_EX = 1'b0; Tnew_EX = 2'd2;
    expect_out("no_regwrite", 0, 0, 0, 0, 0);

    md_seq(1'b0, 5);
    md_seq(1'b1, 10);

    // Freeze over a live RAW hazard: everything holds, no bubble, no count.
    for (int i = 0; i < 3; i++) begin
      tick(); clear_in(); A1_ID = 5'd5; Tuse_rs_ID = 2'd0; A3_EX = 5'd5; RegWrite_EX = 1'b1; Tnew_EX = 2'd2;
      dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
      expect_out("freeze_raw", 0, 1, 0, 0, 0);
    end
    tick(); dmem_ready = 1'b1; expect_out("raw_after_freeze", 1, 0, 0, 0, 0);
    tick(); clear_in(); dmem_req_MEM = 1'b1; dmem_ready = 1'b1;
    expect_out("req_ready_same", 0, 0, 0, 0, 0);

    // 256 consecutive not-ready cycles; the flag must be set once ready returns.
    for (int k = 0; k < 256; k++) begin
      tick(); clear_in(); dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
      expect_out("timeout_wait", 0, 1, 0, 0, 0, k != 255);
    end
    tick(); clear_in(); dmem_req_MEM = 1'b1; dmem_ready = 1'b1;
    expect_out("timeout_set", 0, 0, 0, 0, 1);
    tick(); clear_in(); expect_out("timeout_sticky", 0, 0, 0, 0, 1);

    // Reset in the third BUSY cycle of a divide.
    tick(); md_start_EX = 1'b1; md_div_EX = 1'b1; expect_out("rdiv_start", 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick(); md_start_EX = 1'b0; md_div_EX = 1'b0;
      expect_out("rdiv_busy", 0, 0, 1, 0, 1);
    end
    tick(); rst = 1'b0; exp_scnt = 0; expect_out("rst_mid_busy", 0, 0, 0, 0, 0);
    tick(); rst = 1'b1; expect_out("post_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(); expect_out("no_done_after_rst", 0, 0, 0, 0, 0);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
